axil_read_response: RTL and testbench
=====================================

# axil_read_response

AXI4-Lite read-channel slave for the CL register space: the read-side counterpart of the write request block. Accepts AR requests, decodes the address against a window, and fetches data from the register backend over a simple req/ack port. Returns R beats with OKAY, SLVERR (backend timeout) or DECERR (address outside window). One transaction outstanding at a time.

## Interface
Parameters:
- ADDR_WIDTH, 32: AXI address width.
- ADDR_BASE, 32'h0000_0000: first byte address of the decoded window.
- ADDR_SPAN, 4096: window size in bytes; power of two, ≥ 4.
- TIMEOUT_CYCLES, 255: backend wait limit in cycles; range 1..65535.
- ERR_DATA, 32'hDEAD_BEEF: RDATA returned with SLVERR or DECERR.

Ports:
- clk  in  1  single clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_araddr  in  ADDR_WIDTH  AXI read address.
- i_arvalid  in  1  AXI read address valid.
- o_arready  out  1  AXI read address ready.
- o_rdata  out  32  AXI read data.
- o_rresp  out  2  AXI read response.
- o_rvalid  out  1  AXI read data valid.
- i_rready  in  1  AXI read data ready.
- o_rd_req  out  1  backend read request; level signal.
- o_rd_addr  out  $clog2(ADDR_SPAN/4)  backend word index.
- i_rd_ack  in  1  backend data valid; single-cycle pulse.
- i_rd_data  in  32  backend read data; sampled when i_rd_ack is high.
- o_err_count  out  16  saturating count of SLVERR and DECERR responses.

## Operation
- FSM states IDLE, FETCH, RESP.
- **IDLE**
  - o_arready = 1.
  - On i_arvalid & o_arready: capture i_araddr.
  - If in window (ADDR_BASE ≤ addr < ADDR_BASE+ADDR_SPAN): o_rd_addr = (addr − ADDR_BASE) >> 2, go to FETCH.
  - Otherwise: load rresp = DECERR and rdata = ERR_DATA, go to RESP. The backend is not accessed.
- **FETCH**
  - o_rd_req = 1, o_rd_addr held stable.
  - The timeout counter clears on entry and increments each cycle.
  - On i_rd_ack: latch i_rd_data, rresp = OKAY, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES with no ack: rresp = SLVERR, rdata = ERR_DATA, go to RESP.
  - If ack and timeout occur in the same cycle, the ack wins (OKAY).
- **RESP**
  - o_rvalid = 1; o_rdata and o_rresp are stable until the handshake.
  - On i_rready: go to IDLE.
- Address bits [1:0] are ignored; unaligned addresses read the containing word.
- i_rd_ack outside FETCH is ignored, including a late ack after a timeout.
- o_err_count increments on each SLVERR or DECERR R handshake and saturates at 16'hFFFF.

## Timing
- All outputs are registered.
- Reset values: o_arready = 0, o_rvalid = 0, o_rd_req = 0, o_rdata = 0, o_rresp = 0, o_rd_addr = 0, o_err_count = 0, state = IDLE.
- o_arready rises on the first clk after reset deasserts.
- Reset asserted mid-transaction forces IDLE immediately; the in-flight response is dropped.
- Latency for an in-window read:
  - AR handshake at edge N.
  - o_rd_req high from N+1.
  - Ack at edge N+1+k (k ≥ 0, counting from the first request cycle).
  - o_rvalid high from N+2+k.
- Latency for DECERR: o_rvalid high from N+1.
- Timeout: o_rvalid with SLVERR from N+1+TIMEOUT_CYCLES.
- o_arready is low from N+1 until the cycle after the R handshake. Minimum cadence is 3 cycles per in-window read with zero-wait ack.
- o_rvalid does not deassert without i_rready; AXI stability rules hold.

## Structure
- Shared package axil_pkg holds:
  - axil_resp_t enum: OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11.
  - axil_rd_state_t enum: IDLE, FETCH, RESP.
  - ERR_DATA default constant.
- The write request block imports the same axil_pkg.
- Sub-module axil_timeout_counter holds the clear/enable counter with a terminal-count flag at TIMEOUT_CYCLES. The write side reuses it.

## Test plan
- **Reset:** assert i_reset low mid-FETCH → all outputs return to 0 asynchronously; o_arready = 1 on the first edge after release.
- **Zero-wait read:** araddr = ADDR_BASE+8, backend acks in the first FETCH cycle with 32'h1234_5678 → o_rd_addr = 2, o_rvalid at N+2, rdata = 32'h1234_5678, rresp = OKAY.
- **Out-of-window:** araddr = ADDR_BASE+ADDR_SPAN → o_rd_req never asserts; o_rvalid at N+1 with DECERR and 32'hDEAD_BEEF; o_err_count = 1.
- **Timeout:** TIMEOUT_CYCLES = 4, no ack → SLVERR at N+5. A late ack at N+7 is ignored, and the next read returns fresh data.
- **R backpressure:** hold i_rready low for 10 cycles → o_rvalid, o_rdata and o_rresp stay stable and o_arready stays 0. Handshake on the 11th cycle, then o_arready = 1 on the next cycle.
- **Saturation and race:** force o_err_count to 16'hFFFF, then issue a DECERR → the count stays 16'hFFFF. Ack coincident with terminal count → OKAY with the backend data.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types and helpers for the CL register-space read and write blocks.
package axil_pkg;

  localparam int unsigned AXIL_DATA_W   = 32;
  localparam logic [31:0] AXIL_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } axil_rd_state_t;

  typedef struct packed {
    logic [AXIL_DATA_W-1:0] data;
    axil_resp_t             resp;
  } axil_r_t;

  // Saturating increment for the 16-bit error counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/axil_read_response_if.sv
// AXI4-Lite read address and read data channels.
interface axil_rd_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  import axil_pkg::*;

  logic [ADDR_WIDTH-1:0]  araddr;
  logic                   arvalid;
  logic                   arready;
  logic [AXIL_DATA_W-1:0] rdata;
  axil_resp_t             rresp;
  logic                   rvalid;
  logic                   rready;

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_timeout_counter.sv
// Clear/enable cycle counter; the terminal-count flag marks the last allowed wait cycle.
module axil_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flag is raised during the cycle whose closing edge completes TIMEOUT_CYCLES waits.
  assign o_tc_c = i_enable && (count_q == TC_VAL);

endmodule

// File: rtl/axil_read_response.sv
// AXI4-Lite read slave: window decode, backend fetch with timeout, single outstanding R beat.
module axil_read_response
  import axil_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE      = '0,
  parameter int unsigned           ADDR_SPAN      = 4096,
  parameter int unsigned           TIMEOUT_CYCLES = 255,
  parameter logic [31:0]           ERR_DATA       = AXIL_ERR_DATA,
  localparam int unsigned          IDX_W          = (ADDR_SPAN > 4) ? $clog2(ADDR_SPAN / 4) : 1
) (
  input  logic                   clk,
  input  logic                   i_reset,
  axil_rd_if.slave               bus,
  output logic                   o_rd_req,
  output logic [IDX_W-1:0]       o_rd_addr,
  input  logic                   i_rd_ack,
  input  logic [AXIL_DATA_W-1:0] i_rd_data,
  output logic [15:0]            o_err_count
);

  localparam logic [ADDR_WIDTH:0] SPAN_W = (ADDR_WIDTH + 1)'(ADDR_SPAN);

  axil_rd_state_t        state_q, state_d;
  axil_r_t               r_q, r_d;
  logic [IDX_W-1:0]      rd_addr_q, rd_addr_d;
  logic [15:0]           err_count_q, err_count_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rd_req_q, rd_req_d;
  logic [ADDR_WIDTH-1:0] offset_c;
  logic                  in_window_c;
  logic                  tc_c;

  // Offset is only meaningful once the address is known to be at or above the base.
  assign offset_c    = bus.araddr - ADDR_BASE;
  assign in_window_c = (bus.araddr >= ADDR_BASE) && ({1'b0, offset_c} < SPAN_W);

  axil_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .i_reset (i_reset),
    .i_clear (state_q != FETCH),
    .i_enable(state_q == FETCH),
    .o_tc_c  (tc_c)
  );

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    rd_addr_d   = rd_addr_q;
    err_count_d = err_count_q;
    case (state_q)
      IDLE: begin
        if (bus.arvalid && arready_q) begin
          if (in_window_c) begin
            rd_addr_d = offset_c[IDX_W+1:2];
            state_d   = FETCH;
          end else begin
            r_d     = '{data: ERR_DATA, resp: DECERR};
            state_d = RESP;
          end
        end
      end
      FETCH: begin
        // A coincident ack beats the timeout.
        if (i_rd_ack) begin
          r_d     = '{data: i_rd_data, resp: OKAY};
          state_d = RESP;
        end else if (tc_c) begin
          r_d     = '{data: ERR_DATA, resp: SLVERR};
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rready) begin
          state_d = IDLE;
          if (r_q.resp != OKAY) begin
            err_count_d = sat_inc16(err_count_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    arready_d = (state_d == IDLE);
    rvalid_d  = (state_d == RESP);
    rd_req_d  = (state_d == FETCH);
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      r_q         <= '{data: '0, resp: OKAY};
      rd_addr_q   <= '0;
      err_count_q <= '0;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rd_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      rd_addr_q   <= rd_addr_d;
      err_count_q <= err_count_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rd_req_q    <= rd_req_d;
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = r_q.data;
  assign bus.rresp   = r_q.resp;
  assign o_rd_req    = rd_req_q;
  assign o_rd_addr   = rd_addr_q;
  assign o_err_count = err_count_q;

endmodule

// File: tb/tb_axil_read_response.sv
// Bench for axil_read_response: vector table plus reset, backpressure, late-ack and saturation sequences.
module tb_axil_read_response;
  import axil_pkg::*;

  localparam int unsigned AW   = 32;
  localparam int unsigned T    = 4;
  localparam int unsigned SPAN = 4096;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] EDATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        rd_req;
  logic [9:0]  rd_addr;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic [15:0] err_count;

  axil_rd_if #(.ADDR_WIDTH(AW)) bus ();

  axil_read_response #(
    .ADDR_WIDTH    (AW),
    .ADDR_BASE     (BASE),
    .ADDR_SPAN     (SPAN),
    .TIMEOUT_CYCLES(T),
    .ERR_DATA      (EDATA)
  ) dut (
    .clk        (clk),
    .i_reset    (i_reset),
    .bus        (bus),
    .o_rd_req   (rd_req),
    .o_rd_addr  (rd_addr),
    .i_rd_ack   (rd_ack),
    .i_rd_data  (rd_data),
    .o_err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    int          ack_k;
    logic [31:0] data;
    logic [1:0]  exp_resp;
    int          exp_lat;
    logic [9:0]  exp_idx;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[7];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] err_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Issues one AR, services the backend, then completes R after bp stalled cycles.
  task automatic do_read(input string tag, input logic [31:0] addr, input int ack_k,
                         input logic [31:0] data, input logic [1:0] exp_resp,
                         input int exp_lat, input logic [9:0] exp_idx, input int bp);
    exp_t        e;
    exp_t        got;
    bit          seen;
    int          lat;
    int          req_cnt;
    logic [31:0] cap_data;
    logic [1:0]  cap_resp;
    seen = 0; lat = 0; req_cnt = 0; cap_data = '0; cap_resp = '0;
    check({tag, " arready_before"}, 32'(bus.arready), 32'd1);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    bus.araddr  = 32'hFFFF_FFF0;
    e.data = (exp_resp == OKAY) ? data : EDATA;
    e.resp = exp_resp;
    sb_q.push_back(e);
    for (int m = 0; m < 40; m++) begin
      if (rd_req) begin
        req_cnt++;
        check({tag, " rd_addr"}, 32'(rd_addr), 32'(exp_idx));
      end
      if (bus.rvalid) begin
        seen = 1; lat = m + 1;
        cap_data = bus.rdata; cap_resp = bus.rresp;
        break;
      end
      rd_ack  = (m == ack_k);
      rd_data = rd_ack ? data : 32'h0BAD_0BAD;
      @(posedge clk); #1;
      rd_ack = 1'b0;
    end
    check({tag, " rvalid_seen"}, 32'(seen), 32'd1);
    if (!seen) begin
      void'(sb_q.pop_front());
      return;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " req_cycles"}, 32'(req_cnt), 32'(exp_lat - 1));
    for (int b = 0; b < bp; b++) begin
      @(posedge clk); #1;
      check({tag, " bp_rvalid"}, 32'(bus.rvalid), 32'd1);
      check({tag, " bp_rdata"}, bus.rdata, cap_data);
      check({tag, " bp_rresp"}, 32'(bus.rresp), 32'(cap_resp));
      check({tag, " bp_arready"}, 32'(bus.arready), 32'd0);
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    got.data = cap_data;
    got.resp = cap_resp;
    e = sb_q.pop_front();
    check({tag, " rdata"}, got.data, e.data);
    check({tag, " rresp"}, 32'(got.resp), 32'(e.resp));
    if (e.resp != OKAY && err_model != 16'hFFFF) err_model = err_model + 16'd1;
    check({tag, " rvalid_after"}, 32'(bus.rvalid), 32'd0);
    check({tag, " arready_after"}, 32'(bus.arready), 32'd1);
    check({tag, " err_count"}, 32'(err_count), 32'(err_model));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{"zero_wait",  32'h0000_1008,  0, 32'h1234_5678, OKAY,   2, 10'd2};
    vecs[1] = '{"unaligned",  32'h0000_1013,  2, 32'hA5A5_5A5A, OKAY,   4, 10'd4};
    vecs[2] = '{"decerr_top", 32'h0000_2000, -1, 32'h0,         DECERR, 1, 10'd0};
    vecs[3] = '{"decerr_low", 32'h0000_0FFC, -1, 32'h0,         DECERR, 1, 10'd0};
    vecs[4] = '{"last_word",  32'h0000_1FFF,  1, 32'hCAFE_F00D, OKAY,   3, 10'd1023};
    vecs[5] = '{"timeout",    32'h0000_1040, -1, 32'h0,         SLVERR, 5, 10'd16};
    vecs[6] = '{"ack_race",   32'h0000_1044,  3, 32'h600D_D00D, OKAY,   5, 10'd17};

    err_model   = '0;
    i_reset     = 1'b0;
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    rd_ack      = 1'b0;
    rd_data     = '0;
    #1;
    check("rst arready", 32'(bus.arready), 32'd0);
    check("rst rvalid", 32'(bus.rvalid), 32'd0);
    check("rst rd_req", 32'(rd_req), 32'd0);
    check("rst err_count", 32'(err_count), 32'd0);
    repeat (3) @(posedge clk);
    #1 check("rst arready_held", 32'(bus.arready), 32'd0);
    @(negedge clk);
    i_reset = 1'b1;
    #1 check("release arready_pre_edge", 32'(bus.arready), 32'd0);
    @(posedge clk); #1;
    check("release arready_first_edge", 32'(bus.arready), 32'd1);

    for (int i = 0; i < 7; i++) begin
      do_read(vecs[i].tag, vecs[i].addr, vecs[i].ack_k, vecs[i].data,
              vecs[i].exp_resp, vecs[i].exp_lat, vecs[i].exp_idx, 0);
    end

    do_read("backpressure", BASE + 32'h100, 0, 32'h0102_0304, OKAY, 2, 10'd64, 10);

    // Timeout, then a stray ack two cycles after the R handshake, then a clean read.
    do_read("timeout2", BASE + 32'h80, -1, 32'h0, SLVERR, 5, 10'd32, 0);
    @(posedge clk); #1;
    rd_ack = 1'b1; rd_data = 32'hBAAD_F00D;
    @(posedge clk); #1;
    rd_ack = 1'b0;
    check("late_ack rvalid", 32'(bus.rvalid), 32'd0);
    check("late_ack rd_req", 32'(rd_req), 32'd0);
    check("late_ack arready", 32'(bus.arready), 32'd1);
    do_read("after_late", BASE + 32'h84, 1, 32'h7777_1111, OKAY, 3, 10'd33, 0);

    // Preload the counter at its ceiling; it is forced across an idle edge so the register holds it.
    @(negedge clk);
    force dut.err_count_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.err_count_q;
    @(posedge clk); #1;
    check("sat preload", 32'(err_count), 32'h0000_FFFF);
    err_model = 16'hFFFF;
    do_read("sat_decerr", BASE + 32'h2000, -1, 32'h0, DECERR, 1, 10'd0, 0);

    // Reset in the middle of a backend fetch.
    bus.araddr  = BASE + 32'h20;
    bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    @(posedge clk); #1;
    check("midrst rd_req_before", 32'(rd_req), 32'd1);
    check("midrst rd_addr_before", 32'(rd_addr), 32'd8);
    #2 i_reset = 1'b0;
    #1;
    check("midrst arready", 32'(bus.arready), 32'd0);
    check("midrst rvalid", 32'(bus.rvalid), 32'd0);
    check("midrst rd_req", 32'(rd_req), 32'd0);
    check("midrst rdata", bus.rdata, 32'd0);
    check("midrst rresp", 32'(bus.rresp), 32'd0);
    check("midrst rd_addr", 32'(rd_addr), 32'd0);
    check("midrst err_count", 32'(err_count), 32'd0);
    err_model = '0;
    @(negedge clk);
    i_reset = 1'b1;
    @(posedge clk); #1;
    check("midrst arready_release", 32'(bus.arready), 32'd1);
    do_read("post_reset", BASE + 32'h0C, 0, 32'h5555_AAAA, OKAY, 2, 10'd3, 0);

    check("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
